// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 control sequencer.
// State enum, opcode constants and datapath mux/ALU encodings.
package lc3_ctrl_pkg;

  typedef enum logic [3:0] {
    S_HALTED,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_EXEC_ALU,
    S_BR,
    S_JMP,
    S_LDR1,
    S_LDR2,
    S_LDR3,
    S_STR1,
    S_STR2,
    S_STR3,
    S_PAUSE1,
    S_PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  // States that hold a memory strobe for MEM_WAIT cycles.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory strobe hold counter: counts cycles spent in a wait state and
// flags the last one. Saturates at MEM_WAIT-1 so it never wraps.
module mem_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(MEM_WAIT) + 1;

  logic [W-1:0] count;

  assign done = (count == W'(MEM_WAIT - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (clear) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// LC-3 fetch/decode/execute control FSM (Moore): drives datapath load
// enables, bus gates, mux selects and memory strobes from the state register.
module control_sequencer
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_PC,
  output logic        LD_REG,
  output logic        LD_CC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        SR2MUX,
  output logic [1:0]  ALUK,
  output logic        Mem_OE,
  output logic        Mem_WE
);

  state_t     state;
  state_t     next_state;
  logic       ben;
  logic       wait_en;
  logic       wait_clear;
  logic       wait_done;
  logic [3:0] opcode;

  assign opcode = IR[15:12];

  // Counter is held at zero outside wait states, so it starts from zero on
  // every entry; wait states are never back-to-back.
  assign wait_en    = is_wait_state(state);
  assign wait_clear = Reset || !wait_en;

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk   (Clk),
    .clear (wait_clear),
    .en    (wait_en),
    .done  (wait_done)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_HALTED;
      ben   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        ben <= |(IR[11:9] & {N, Z, P});
      end
    end
  end

  always_comb begin
    // NOTE: a default assignment before the case keeps every path assigned,
    // so no latch is inferred for next_state or the outputs below.
    next_state = state;
    unique case (state)
      S_HALTED:   if (Run) next_state = S_FETCH1;
      S_FETCH1:   next_state = S_FETCH2;
      S_FETCH2:   if (wait_done) next_state = S_FETCH3;
      S_FETCH3:   next_state = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_ADD, OP_AND, OP_NOT: next_state = S_EXEC_ALU;
          OP_BR:                  next_state = S_BR;
          OP_JMP:                 next_state = S_JMP;
          OP_LDR:                 next_state = S_LDR1;
          OP_STR:                 next_state = S_STR1;
          OP_PAUSE:               next_state = S_PAUSE1;
          default:                next_state = S_FETCH1;
        endcase
      end
      S_EXEC_ALU: next_state = S_FETCH1;
      S_BR:       next_state = S_FETCH1;
      S_JMP:      next_state = S_FETCH1;
      S_LDR1:     next_state = S_LDR2;
      S_LDR2:     if (wait_done) next_state = S_LDR3;
      S_LDR3:     next_state = S_FETCH1;
      S_STR1:     next_state = S_STR2;
      S_STR2:     next_state = S_STR3;
      S_STR3:     if (wait_done) next_state = S_FETCH1;
      S_PAUSE1:   if (Continue) next_state = S_PAUSE2;
      S_PAUSE2:   if (!Continue) next_state = S_FETCH1;
      default:    next_state = S_HALTED;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_PC      = 1'b0;
    LD_REG     = 1'b0;
    LD_CC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_INC;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2_ZERO;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = IR[5];
    ALUK       = ALUK_ADD;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    unique case (state)
      S_FETCH1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S_FETCH2, S_LDR2: begin
        Mem_OE = 1'b1;
        LD_MDR = 1'b1;
      end
      S_FETCH3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_EXEC_ALU: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        unique case (opcode)
          OP_AND:  ALUK = ALUK_AND;
          OP_NOT:  ALUK = ALUK_NOT;
          default: ALUK = ALUK_ADD;
        endcase
      end
      S_BR: begin
        // Taken/not-taken uses ben latched in DECODE, not live N/Z/P.
        if (ben) begin
          LD_PC    = 1'b1;
          PCMUX    = PCMUX_ADDR;
          ADDR2MUX = ADDR2_OFF9;
        end
      end
      S_JMP: begin
        LD_PC    = 1'b1;
        PCMUX    = PCMUX_ADDR;
        ADDR1MUX = 1'b1;
      end
      S_LDR1, S_STR1: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_OFF6;
      end
      S_LDR3: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_STR2: begin
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
        SR1MUX  = 1'b1;
        ALUK    = ALUK_PASS;
      end
      S_STR3:   Mem_WE = 1'b1;
      S_PAUSE1: LD_LED = 1'b1;
      default: ;
    endcase
  end

  // IR fields consumed by the datapath rather than the sequencer.
  logic unused_ir;
  assign unused_ir = ^{IR[8:6], IR[4:0]};

endmodule
